mem_subword_unit: RTL and testbench

Data-memory access unit between the multicycle datapath's memory-stage control and the data RAM (ramD). It converts a single load/store request, qualified by funct3, into word-wide RAM transactions. Loads return sign- or zero-extended results; byte and halfword stores use an internal read-modify-write. The datapath issues one request and waits for oDone; the unit owns the RAM address, write data and write enable.

---
 rtl/mem_subword_unit.sv | 127 ++++++++++++
 tb/tb_mem_subword_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_subword_unit.sv
// Data-memory access unit: turns one load/store request into word-wide RAM cycles,
// with sign/zero-extended loads and read-modify-write for byte/half stores.
module mem_subword_unit #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic                 iReq,
   input  logic                 iWrite,
   input  logic [2:0]           iFunct3,
   input  logic [31:0]          iAddr,
   input  logic [31:0]          iWData,
   output logic [31:0]          oRData,
   output logic                 oBusy,
   output logic                 oDone,
   output logic                 oMisaligned,
   output logic [ADDR_BITS-1:0] oMemAddr,
   output logic [31:0]          oMemWData,
   output logic                 oMemWren,
   input  logic [31:0]          iMemQ
);

   typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_DONE} state_t;

   state_t                r_state, w_next;
   logic                  r_write;
   logic [2:0]            r_f3;
   logic [ADDR_BITS+1:0]  r_addr;
   logic [15:0]           r_wsub;
   logic [31:0]           r_buf, r_rdata, r_memwdata;
   logic                  r_err, r_done, r_wren;
   logic                  w_err;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_load, w_merge;
   logic                  w_unused;

   assign w_unused = ^iAddr[31:ADDR_BITS+2];

   always_comb begin
      w_err = 1'b0;
      case (iFunct3)
         3'b000:         w_err = 1'b0;
         3'b001:         w_err = iAddr[0];
         3'b010:         w_err = |iAddr[1:0];
         3'b100, 3'b101: w_err = iWrite | (iFunct3[0] & iAddr[0]);
         default:        w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (iReq) begin
            if (w_err)                          w_next = S_DONE;
            else if (iWrite && iFunct3 == 3'b010) w_next = S_WR;
            else                                w_next = S_RD1;
         end
         S_RD1:  w_next = S_RD2;
         S_RD2:  w_next = r_write ? S_WR : S_DONE;
         S_WR:   w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Lane selection on the RAM word, little-endian
   always_comb begin
      w_byte  = iMemQ[{r_addr[1:0], 3'b000} +: 8];
      w_half  = iMemQ[{r_addr[1], 4'b0000} +: 16];
      w_load  = iMemQ;
      case (r_f3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = iMemQ;
      endcase
      w_merge = iMemQ;
      if (r_f3[0]) w_merge[{r_addr[1], 4'b0000} +: 16] = r_wsub;
      else         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wsub[7:0];
   end

   // Done/wren are registered off the state, so they trail it by one cycle
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_f3       <= '0;
         r_addr     <= '0;
         r_wsub     <= '0;
         r_buf      <= '0;
         r_rdata    <= '0;
         r_memwdata <= '0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_wren     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_DONE);
         r_wren  <= (r_state == S_WR);
         case (r_state)
            S_IDLE: if (iReq) begin
               r_write <= iWrite;
               r_f3    <= iFunct3;
               r_addr  <= iAddr[ADDR_BITS+1:0];
               r_wsub  <= iWData[15:0];
               r_buf   <= iWData;
               r_err   <= w_err;
            end
            S_RD2:  r_buf <= r_write ? w_merge : w_load;
            S_WR:   r_memwdata <= r_buf;
            S_DONE: if (!r_write && !r_err) r_rdata <= r_buf;
            default: ;
         endcase
      end
   end

   assign oRData      = r_rdata;
   assign oBusy       = (r_state != S_IDLE);
   assign oDone       = r_done;
   assign oMisaligned = r_err;
   assign oMemAddr    = r_addr[ADDR_BITS+1:2];
   assign oMemWData   = r_memwdata;
   assign oMemWren    = r_wren;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Bench for mem_subword_unit: directed vector table, reset/back-to-back sequences,
// and random requests checked against a word-array reference model.
module tb_mem_subword_unit;

   logic        iCLK = 1'b0;
   logic        iRST, iReq, iWrite;
   logic [2:0]  iFunct3;
   logic [31:0] iAddr, iWData, oRData, oMemWData, iMemQ;
   logic        oBusy, oDone, oMisaligned, oMemWren;
   logic [9:0]  oMemAddr;

   mem_subword_unit #(.ADDR_BITS(10)) dut (
      .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
      .iAddr(iAddr), .iWData(iWData), .oRData(oRData), .oBusy(oBusy), .oDone(oDone),
      .oMisaligned(oMisaligned), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
      .oMemWren(oMemWren), .iMemQ(iMemQ)
   );

   always #5 iCLK = ~iCLK;

   // RAM environment: synchronous read, write on wren, plus a bench preload port
   logic [31:0] ram [0:1023] = '{default: 32'h0};
   logic [31:0] mref [0:1023] = '{default: 32'h0};
   logic        pre_en = 1'b0;
   logic [9:0]  pre_a = '0;
   logic [31:0] pre_d = '0;
   always @(posedge iCLK) begin
      if (pre_en)        ram[pre_a] <= pre_d;
      else if (oMemWren) ram[oMemAddr] <= oMemWData;
      iMemQ <= ram[oMemAddr];
   end

   int checks = 0, errors = 0;
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      pre_a = a; pre_d = d; pre_en = 1'b1;
      @(posedge iCLK); #1;
      pre_en = 1'b0;
      mref[a] = d;
   endtask

   // Reference model: plain arithmetic on access size and byte offset
   function automatic logic m_err(logic w, logic [2:0] f, logic [31:0] a);
      int sz;
      if (f == 3 || f == 6 || f == 7) return 1'b1;
      if (w && f[2]) return 1'b1;
      sz = 1 << f[1:0];
      return (a % sz) != 0;
   endfunction

   function automatic int m_lat(logic w, logic [2:0] f, logic e);
      if (e) return 1;
      if (w) return (f == 3'b010) ? 2 : 4;
      return 3;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] word, logic [2:0] f, logic [31:0] a);
      logic [31:0] v;
      v = word >> (8 * (a % 4));
      case (f)
         3'd0: return {{24{v[7]}}, v[7:0]};
         3'd1: return {{16{v[15]}}, v[15:0]};
         3'd4: return v & 32'hFF;
         3'd5: return v & 32'hFFFF;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] m_store(logic [31:0] word, logic [2:0] f, logic [31:0] a,
                                           logic [31:0] d);
      logic [31:0] mask;
      int sh;
      mask = (f == 0) ? 32'hFF : (f == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      sh   = 8 * (a % 4);
      return (word & ~(mask << sh)) | ((d & mask) << sh);
   endfunction

   // Issue one request from the sampling point; latency counted in edges after acceptance
   task automatic run_req(input string nm, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input int e_lat, input logic [31:0] e_val);
      int lat, nwr;
      logic [31:0] wa_s, wd_s;
      logic err_s, busy0;
      iReq = 1'b1; iWrite = w; iFunct3 = f; iAddr = a; iWData = d;
      @(posedge iCLK); #1;
      iReq = 1'b0;
      busy0 = oBusy;
      lat = 0; nwr = 0; err_s = 1'b0; wa_s = '0; wd_s = '0;
      if (oMemWren) nwr++;
      for (int k = 1; k <= 10; k++) begin
         @(posedge iCLK); #1;
         if (oMemWren) begin nwr++; wa_s = {22'h0, oMemAddr}; wd_s = oMemWData; end
         if (oDone) begin lat = k; err_s = oMisaligned; break; end
      end
      chk({nm, " busy"}, {31'h0, busy0}, 32'd1);
      chk({nm, " latency"}, lat, e_lat);
      chk({nm, " misaligned"}, {31'h0, err_s}, {31'h0, e_err});
      if (w && !e_err) begin
         chk({nm, " wren count"}, nwr, 1);
         chk({nm, " wr addr"}, wa_s, {22'h0, a[11:2]});
         chk({nm, " wr data"}, wd_s, e_val);
         chk({nm, " ram word"}, ram[a[11:2]], e_val);
         mref[a[11:2]] = e_val;
      end else begin
         chk({nm, " no wren"}, nwr, 0);
      end
      if (!w && !e_err) last_rd = e_val;
      chk({nm, " rdata"}, oRData, last_rd);
   endtask

   typedef struct {
      logic        pre;
      logic [31:0] pre_val;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        e_err;
      int          e_lat;
      logic [31:0] e_val;
   } vec_t;

   vec_t vt [13];

   initial begin
      int mask, lat5;
      logic [31:0] a, d, v;
      logic w, e;
      logic [2:0] f;

      vt[0]  = '{1, 32'h8899AABB, 0, 3'd2, 32'h10000010, 32'h0,        0, 3, 32'h8899AABB};
      vt[1]  = '{0, 32'h0,        0, 3'd0, 32'h10000011, 32'h0,        0, 3, 32'hFFFFFFAA};
      vt[2]  = '{0, 32'h0,        0, 3'd4, 32'h10000011, 32'h0,        0, 3, 32'h000000AA};
      vt[3]  = '{0, 32'h0,        0, 3'd1, 32'h10000012, 32'h0,        0, 3, 32'hFFFF8899};
      vt[4]  = '{0, 32'h0,        0, 3'd5, 32'h10000012, 32'h0,        0, 3, 32'h00008899};
      vt[5]  = '{1, 32'h11223344, 1, 3'd0, 32'h10000013, 32'hDEADBEEF, 0, 4, 32'hEF223344};
      vt[6]  = '{0, 32'h0,        1, 3'd1, 32'h10000010, 32'h0000CAFE, 0, 4, 32'hEF22CAFE};
      vt[7]  = '{0, 32'h0,        1, 3'd2, 32'h10000020, 32'h12345678, 0, 2, 32'h12345678};
      vt[8]  = '{0, 32'h0,        0, 3'd2, 32'h10000012, 32'h0,        1, 1, 32'h0};
      vt[9]  = '{0, 32'h0,        1, 3'd1, 32'h10000011, 32'h0000BEEF, 1, 1, 32'h0};
      vt[10] = '{0, 32'h0,        0, 3'd3, 32'h10000010, 32'h0,        1, 1, 32'h0};
      vt[11] = '{0, 32'h0,        1, 3'd4, 32'h10000010, 32'h000000AA, 1, 1, 32'h0};
      vt[12] = '{0, 32'h0,        0, 3'd2, 32'h10000010, 32'h0,        0, 3, 32'hEF22CAFE};

      // Reset asserted with a request pending: reset wins
      iRST = 1'b0; iReq = 1'b1; iWrite = 1'b1; iFunct3 = 3'd2;
      iAddr = 32'h10000020; iWData = 32'hFFFFFFFF;
      repeat (3) @(posedge iCLK);
      #1;
      chk("reset busy", {31'h0, oBusy}, 32'd0);
      chk("reset done/mis/wren", {29'h0, oDone, oMisaligned, oMemWren}, 32'd0);
      chk("reset rdata", oRData, 32'h0);
      chk("reset memaddr", {22'h0, oMemAddr}, 32'h0);
      chk("reset memwdata", oMemWData, 32'h0);
      iReq = 1'b0; iRST = 1'b1;
      @(posedge iCLK); #1;

      foreach (vt[i]) begin
         if (vt[i].pre) preload(vt[i].addr[11:2], vt[i].pre_val);
         run_req($sformatf("vec%0d", i), vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wd,
                 vt[i].e_err, vt[i].e_lat, vt[i].e_val);
      end

      // Reset during RD2 of a byte store aborts it
      preload(10'd5, 32'h55667788);
      iReq = 1'b1; iWrite = 1'b1; iFunct3 = 3'd0; iAddr = 32'h10000015; iWData = 32'h000000EE;
      @(posedge iCLK); #1;
      iReq = 1'b0;
      @(posedge iCLK); #1;
      iRST = 1'b0;
      @(posedge iCLK); #1;
      chk("abort busy", {31'h0, oBusy}, 32'd0);
      chk("abort done/mis/wren", {29'h0, oDone, oMisaligned, oMemWren}, 32'd0);
      chk("abort rdata", oRData, 32'h0);
      chk("abort memaddr/wdata", {22'h0, oMemAddr} | oMemWData, 32'h0);
      iRST = 1'b1;
      last_rd = 32'h0;
      mask = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge iCLK); #1;
         if (oMemWren || oDone) mask = 1;
      end
      chk("abort no wren/done", mask, 0);
      chk("abort ram", ram[5], 32'h55667788);

      // iReq held high: second accept only on the edge after DONE
      iReq = 1'b1; iWrite = 1'b0; iFunct3 = 3'd2; iAddr = 32'h10000014; iWData = 32'h0;
      @(posedge iCLK); #1;
      mask = 0; lat5 = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge iCLK); #1;
         if (oDone) mask |= (1 << k);
         if (k == 3) lat5 = {31'h0, oBusy};
         if (k == 4) iReq = 1'b0;
      end
      chk("held req done pulses", mask, 32'h88);
      chk("held req idle gap", lat5, 0);
      chk("held req rdata", oRData, 32'h55667788);
      last_rd = 32'h55667788;

      // Random requests against the model
      for (int i = 0; i < 8; i++) preload(10'(i), $urandom);
      for (int i = 0; i < 150; i++) begin
         w = 1'($urandom_range(0, 1));
         f = 3'($urandom_range(0, 7));
         a = 32'h10000000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         e = m_err(w, f, a);
         if (e)      v = 32'h0;
         else if (w) v = m_store(mref[a[11:2]], f, a, d);
         else        v = m_load(mref[a[11:2]], f, a);
         run_req($sformatf("rnd%0d", i), w, f, a, d, e, m_lat(w, f, e), v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
